// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter granting the shared block-RAM port A to the CPU or the IO requester.
// Grant 1 cycle after sampling req, ack 1 cycle later; a loser holds req until it wins the next IDLE.
module mem_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_gnt,
    output logic              io_ack,
    output logic [DATA_W-1:0] io_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic [1:0]        owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_IO   = 2'b10;

    state_t            state, state_nxt;
    logic              last_io, last_io_nxt;
    logic              pick_io;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt;
    logic              mem_we_nxt;
    logic              cpu_gnt_nxt, io_gnt_nxt;
    logic              cpu_ack_nxt, io_ack_nxt;
    logic [1:0]        owner_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last_io   <= 1'b1;  // CPU wins the first tie
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            cpu_gnt   <= 1'b0;
            io_gnt    <= 1'b0;
            cpu_ack   <= 1'b0;
            io_ack    <= 1'b0;
            owner     <= OWN_NONE;
        end else begin
            state     <= state_nxt;
            last_io   <= last_io_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            mem_we    <= mem_we_nxt;
            cpu_gnt   <= cpu_gnt_nxt;
            io_gnt    <= io_gnt_nxt;
            cpu_ack   <= cpu_ack_nxt;
            io_ack    <= io_ack_nxt;
            owner     <= owner_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        last_io_nxt   = last_io;
        pick_io       = 1'b0;
        mem_addr_nxt  = mem_addr;   // address/data hold between grants
        mem_wdata_nxt = mem_wdata;
        mem_we_nxt    = 1'b0;
        cpu_gnt_nxt   = 1'b0;
        io_gnt_nxt    = 1'b0;
        cpu_ack_nxt   = 1'b0;
        io_ack_nxt    = 1'b0;
        owner_nxt     = owner;

        case (state)
            IDLE: begin
                owner_nxt = OWN_NONE;
                if (cpu_req || io_req) begin
                    pick_io       = io_req && (!cpu_req || !last_io);
                    state_nxt     = ACCESS;
                    last_io_nxt   = pick_io;
                    owner_nxt     = pick_io ? OWN_IO : OWN_CPU;
                    mem_addr_nxt  = pick_io ? io_addr  : cpu_addr;
                    mem_wdata_nxt = pick_io ? io_wdata : cpu_wdata;
                    mem_we_nxt    = pick_io ? io_we    : cpu_we;
                    cpu_gnt_nxt   = !pick_io;
                    io_gnt_nxt    = pick_io;
                end
            end
            ACCESS: begin
                state_nxt   = RESP;
                cpu_ack_nxt = (owner == OWN_CPU);
                io_ack_nxt  = (owner == OWN_IO);
            end
            RESP: begin
                // req is never sampled here; the winner drops it on seeing ack
                state_nxt = IDLE;
                owner_nxt = OWN_NONE;
            end
            default: begin
                state_nxt = IDLE;
                owner_nxt = OWN_NONE;
            end
        endcase
    end

    assign cpu_rdata = cpu_ack ? mem_rdata : '0;
    assign io_rdata  = io_ack  ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous RAM on the memory port.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, io_req, io_we;
    logic [15:0] cpu_addr, cpu_wdata, io_addr, io_wdata;
    logic        cpu_gnt, cpu_ack, io_gnt, io_ack;
    logic [15:0] cpu_rdata, io_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [1:0]  owner;

    int n_tests = 0;
    int n_fail  = 0;
    int both_gnt_cnt = 0;

    logic [15:0] ram [0:255];
    logic        bk_we;
    logic [7:0]  bk_addr;
    logic [15:0] bk_dat;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_gnt(io_gnt), .io_ack(io_ack), .io_rdata(io_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .owner(owner)
    );

    // Read-first synchronous RAM with a backdoor load port for preloading.
    always @(posedge clk) begin
        if (bk_we)
            ram[bk_addr] <= bk_dat;
        else if (mem_we)
            ram[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[7:0]];
    end

    always @(negedge clk)
        if (cpu_gnt && io_gnt) both_gnt_cnt = both_gnt_cnt + 1;

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        io_req  = 0; io_we  = 0; io_addr  = 0; io_wdata  = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bk_we = 0; bk_addr = 0; bk_dat = 0;
        reset = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            bk_we = 1; bk_addr = i[7:0]; bk_dat = (i == 16) ? 16'hBEEF : 16'h0000;
        end
        @(negedge clk); bk_we = 0;
        @(negedge clk);
        n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
        n_tests++; if (mem_addr !== 16'h0) begin n_fail++; $display("FAIL reset_mem_addr got %h exp 0000", mem_addr); end
        n_tests++; if (mem_wdata !== 16'h0) begin n_fail++; $display("FAIL reset_mem_wdata got %h exp 0000", mem_wdata); end
        n_tests++; if ({cpu_gnt, io_gnt, cpu_ack, io_ack} !== 4'b0) begin n_fail++; $display("FAIL reset_gnt_ack got %b exp 0000", {cpu_gnt, io_gnt, cpu_ack, io_ack}); end
        n_tests++; if (owner !== 2'b00) begin n_fail++; $display("FAIL reset_owner got %b exp 00", owner); end
        n_tests++; if ({cpu_rdata, io_rdata} !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", {cpu_rdata, io_rdata}); end
        reset = 1;
        @(negedge clk);
    endtask

    task automatic test_cpu_read();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        @(negedge clk);
        n_tests++; if ({cpu_gnt, io_gnt} !== 2'b10) begin n_fail++; $display("FAIL cpu_rd_gnt got %b exp 10", {cpu_gnt, io_gnt}); end
        n_tests++; if (mem_addr !== 16'h0010 || mem_we !== 1'b0) begin n_fail++; $display("FAIL cpu_rd_mem got addr %h we %b exp 0010 0", mem_addr, mem_we); end
        n_tests++; if (owner !== 2'b01) begin n_fail++; $display("FAIL cpu_rd_owner got %b exp 01", owner); end
        @(negedge clk);
        n_tests++; if ({cpu_ack, io_ack, cpu_gnt} !== 3'b100) begin n_fail++; $display("FAIL cpu_rd_ack got %b exp 100", {cpu_ack, io_ack, cpu_gnt}); end
        n_tests++; if (cpu_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL cpu_rd_data got %h exp beef", cpu_rdata); end
        cpu_req = 0;
        @(negedge clk);
        n_tests++; if ({cpu_ack, owner} !== 3'b000) begin n_fail++; $display("FAIL cpu_rd_idle got ack %b owner %b exp 0 00", cpu_ack, owner); end
    endtask

    task automatic test_io_write_read();
        io_req = 1; io_we = 1; io_addr = 16'h0020; io_wdata = 16'h1234;
        @(negedge clk);
        n_tests++; if ({io_gnt, cpu_gnt, mem_we} !== 3'b101) begin n_fail++; $display("FAIL io_wr_gnt got gnt/cpu/we %b exp 101", {io_gnt, cpu_gnt, mem_we}); end
        n_tests++; if (mem_addr !== 16'h0020 || mem_wdata !== 16'h1234) begin n_fail++; $display("FAIL io_wr_mem got %h %h exp 0020 1234", mem_addr, mem_wdata); end
        n_tests++; if (owner !== 2'b10) begin n_fail++; $display("FAIL io_wr_owner got %b exp 10", owner); end
        @(negedge clk);
        n_tests++; if ({io_ack, mem_we, io_gnt} !== 3'b100) begin n_fail++; $display("FAIL io_wr_ack got ack/we/gnt %b exp 100", {io_ack, mem_we, io_gnt}); end
        io_req = 0;
        @(negedge clk);
        io_req = 1; io_we = 0; io_wdata = 16'h0;
        @(negedge clk);
        n_tests++; if ({io_gnt, mem_we} !== 2'b10) begin n_fail++; $display("FAIL io_rd_gnt got gnt/we %b exp 10", {io_gnt, mem_we}); end
        @(negedge clk);
        n_tests++; if (io_ack !== 1'b1 || io_rdata !== 16'h1234) begin n_fail++; $display("FAIL io_rd_data got ack %b data %h exp 1 1234", io_ack, io_rdata); end
        io_req = 0;
        @(negedge clk);
        n_tests++; if (mem_addr !== 16'h0020 || io_rdata !== 16'h0) begin n_fail++; $display("FAIL io_rd_hold got addr %h rdata %h exp 0020 0000", mem_addr, io_rdata); end
    endtask

    task automatic test_first_tie();
        reset = 0;
        @(negedge clk);
        reset = 1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        io_req  = 1; io_we  = 0; io_addr  = 16'h0020;
        @(negedge clk);
        n_tests++; if ({cpu_gnt, io_gnt, owner} !== 4'b1001) begin n_fail++; $display("FAIL tie_first got gnt %b%b owner %b exp 10 01", cpu_gnt, io_gnt, owner); end
        @(negedge clk);
        n_tests++; if ({cpu_ack, io_ack} !== 2'b10 || cpu_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL tie_first_ack got %b %h exp 10 beef", {cpu_ack, io_ack}, cpu_rdata); end
        cpu_req = 0;
        @(negedge clk);
        n_tests++; if ({cpu_gnt, io_gnt} !== 2'b00) begin n_fail++; $display("FAIL tie_idle got %b exp 00", {cpu_gnt, io_gnt}); end
        @(negedge clk);
        n_tests++; if ({cpu_gnt, io_gnt, owner} !== 4'b0110) begin n_fail++; $display("FAIL tie_second got gnt %b%b owner %b exp 01 10", cpu_gnt, io_gnt, owner); end
        @(negedge clk);
        n_tests++; if ({cpu_ack, io_ack} !== 2'b01 || io_rdata !== 16'h1234) begin n_fail++; $display("FAIL tie_second_ack got %b %h exp 01 1234", {cpu_ack, io_ack}, io_rdata); end
        io_req = 0;
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic exp_io;
        both_gnt_cnt = 0;
        cpu_req = 1; io_req = 1; cpu_we = 0; io_we = 0;
        for (int t = 0; t < 6; t++) begin
            exp_io = t[0];
            @(negedge clk);
            n_tests++; if ({cpu_gnt, io_gnt} !== {!exp_io, exp_io}) begin n_fail++; $display("FAIL contend_gnt%0d got %b exp %b", t, {cpu_gnt, io_gnt}, {!exp_io, exp_io}); end
            @(negedge clk);
            n_tests++; if ({cpu_ack, io_ack} !== {!exp_io, exp_io}) begin n_fail++; $display("FAIL contend_ack%0d got %b exp %b", t, {cpu_ack, io_ack}, {!exp_io, exp_io}); end
            if (exp_io) io_req = 0; else cpu_req = 0;
            @(negedge clk);
            if (exp_io) io_req = 1; else cpu_req = 1;
        end
        cpu_req = 0; io_req = 0;
        @(negedge clk);
        n_tests++; if (both_gnt_cnt !== 0) begin n_fail++; $display("FAIL contend_both_gnt got %0d cycles exp 0", both_gnt_cnt); end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0030; cpu_wdata = 16'h5555;
        @(negedge clk);
        n_tests++; if ({cpu_gnt, mem_we} !== 2'b11) begin n_fail++; $display("FAIL rstw_access got gnt/we %b exp 11", {cpu_gnt, mem_we}); end
        #2 reset = 0;
        #1;
        n_tests++; if ({mem_we, cpu_gnt, owner} !== 4'b0000) begin n_fail++; $display("FAIL rstw_async got we/gnt/owner %b exp 0000", {mem_we, cpu_gnt, owner}); end
        @(negedge clk);
        n_tests++; if (cpu_ack !== 1'b0 || ram[8'h30] !== 16'h0) begin n_fail++; $display("FAIL rstw_discard got ack %b ram %h exp 0 0000", cpu_ack, ram[8'h30]); end
        reset = 1;
        @(negedge clk);
        n_tests++; if ({cpu_gnt, mem_we, owner} !== 4'b1101) begin n_fail++; $display("FAIL rstw_regrant got gnt/we/owner %b exp 1101", {cpu_gnt, mem_we, owner}); end
        @(negedge clk);
        n_tests++; if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL rstw_ack got %b exp 1", cpu_ack); end
        cpu_req = 0;
        @(negedge clk);
        n_tests++; if (ram[8'h30] !== 16'h5555) begin n_fail++; $display("FAIL rstw_ram got %h exp 5555", ram[8'h30]); end
    endtask

    task automatic test_withdrawn();
        int seen;
        seen = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        @(negedge clk);
        @(negedge clk);
        n_tests++; if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL wd_cpu_ack got %b exp 1", cpu_ack); end
        cpu_req = 0;
        io_req = 1; io_we = 1; io_addr = 16'h0040; io_wdata = 16'hDEAD;
        @(negedge clk);
        io_req = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (io_gnt || mem_we || io_ack) seen++;
        end
        n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL wd_no_grant got %0d active cycles exp 0", seen); end
        n_tests++; if (ram[8'h40] !== 16'h0) begin n_fail++; $display("FAIL wd_no_write got %h exp 0000", ram[8'h40]); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_cpu_read();
        test_io_write_read();
        test_first_tie();
        test_contention();
        test_reset_mid_write();
        test_withdrawn();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
